// File: rtl/riscv_pkg.sv
// Shared RISC-V decode types.
// Immediate formats, datapath widths and stage occupancy.
package riscv_pkg;

   localparam int XLEN_32 = 32;
   localparam int XLEN_64 = 64;

   typedef enum logic [2:0] {
      IMM_I     = 3'd0,
      IMM_ISTAR = 3'd1,
      IMM_S     = 3'd2,
      IMM_B     = 3'd3,
      IMM_U     = 3'd4,
      IMM_J     = 3'd5,
      IMM_R     = 3'd6,
      IMM_Z     = 3'd7
   } imm_type_e;

   typedef enum logic [1:0] {
      OCC_EMPTY = 2'd0,
      OCC_ONE   = 2'd1,
      OCC_TWO   = 2'd2
   } occ_e;

endpackage

// File: rtl/imm_decode_comb.sv
// Combinational RISC-V immediate decoder.
// Maps (inst, imm_type) to an XLEN immediate and a shamt legality flag.
module imm_decode_comb
   import riscv_pkg::*;
#(
   parameter int XLEN = XLEN_32
) (
   input  logic [31:0]     inst,
   input  imm_type_e       imm_type,
   output logic [XLEN-1:0] imm,
   output logic            shamt_err
);

   // Opcode bits carry no immediate information.
   logic unused_opcode;
   assign unused_opcode = ^inst[6:0];

   function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
      return XLEN'($signed(v));
   endfunction

   // Select the immediate format; every path drives every bit.
   always_comb begin
      imm       = '0;
      shamt_err = 1'b0;
      unique case (imm_type)
         IMM_I: imm = sext32({{20{inst[31]}}, inst[31:20]});
         IMM_S: imm = sext32({{20{inst[31]}}, inst[31:25], inst[11:7]});
         IMM_B: imm = sext32({{19{inst[31]}}, inst[31], inst[7],
                              inst[30:25], inst[11:8], 1'b0});
         IMM_U: imm = sext32({inst[31:12], 12'b0});
         IMM_J: imm = sext32({{11{inst[31]}}, inst[31], inst[19:12],
                              inst[20], inst[30:21], 1'b0});
         IMM_ISTAR: begin
            if (XLEN == XLEN_64) begin
               imm = XLEN'(inst[25:20]);
            end else begin
               imm       = XLEN'(inst[24:20]);
               shamt_err = inst[25];
            end
         end
         IMM_Z:   imm = XLEN'(inst[19:15]);
         IMM_R:   imm = '0;
         default: imm = '0;
      endcase
   end

endmodule

// File: rtl/imm_gen_stage.sv
// Registered immediate generator stage with skid buffer.
// Produces imm, pc + imm and shamt_err one cycle after acceptance.
module imm_gen_stage
   import riscv_pkg::*;
#(
   parameter int XLEN = XLEN_32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     inst,
   input  logic [2:0]      imm_type,
   input  logic [XLEN-1:0] pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] imm,
   output logic [XLEN-1:0] pc_target,
   output logic            shamt_err
);

   if (XLEN != XLEN_32 && XLEN != XLEN_64) begin : g_bad_xlen
      $error("imm_gen_stage: XLEN must be 32 or 64");
   end

   imm_type_e       type_in;
   logic [XLEN-1:0] dec_imm;
   logic [XLEN-1:0] dec_tgt;
   logic            dec_err;

   occ_e            state_q, state_d;
   logic [XLEN-1:0] out_imm_q, out_imm_d;
   logic [XLEN-1:0] out_tgt_q, out_tgt_d;
   logic            out_err_q, out_err_d;
   logic [XLEN-1:0] skid_imm_q, skid_imm_d;
   logic [XLEN-1:0] skid_tgt_q, skid_tgt_d;
   logic            skid_err_q, skid_err_d;

   logic            accept;
   logic            deliver;

   assign type_in = imm_type_e'(imm_type);

   imm_decode_comb #(
      .XLEN (XLEN)
   ) u_dec (
      .inst      (inst),
      .imm_type  (type_in),
      .imm       (dec_imm),
      .shamt_err (dec_err)
   );

   assign dec_tgt = pc + dec_imm;

   assign in_ready  = (state_q != OCC_TWO);
   assign out_valid = (state_q != OCC_EMPTY);
   assign imm       = out_imm_q;
   assign pc_target = out_tgt_q;
   assign shamt_err = out_err_q;

   assign accept  = in_valid & in_ready;
   assign deliver = out_valid & out_ready;

   // Occupancy next-state and output/skid register steering.
   always_comb begin
      state_d    = state_q;
      out_imm_d  = out_imm_q;
      out_tgt_d  = out_tgt_q;
      out_err_d  = out_err_q;
      skid_imm_d = skid_imm_q;
      skid_tgt_d = skid_tgt_q;
      skid_err_d = skid_err_q;
      unique case (state_q)
         OCC_EMPTY: begin
            if (accept) begin
               state_d   = OCC_ONE;
               out_imm_d = dec_imm;
               out_tgt_d = dec_tgt;
               out_err_d = dec_err;
            end
         end
         OCC_ONE: begin
            if (accept && deliver) begin
               out_imm_d = dec_imm;
               out_tgt_d = dec_tgt;
               out_err_d = dec_err;
            end else if (accept) begin
               state_d    = OCC_TWO;
               skid_imm_d = dec_imm;
               skid_tgt_d = dec_tgt;
               skid_err_d = dec_err;
            end else if (deliver) begin
               state_d = OCC_EMPTY;
            end
         end
         OCC_TWO: begin
            if (deliver) begin
               state_d   = OCC_ONE;
               out_imm_d = skid_imm_q;
               out_tgt_d = skid_tgt_q;
               out_err_d = skid_err_q;
            end
         end
         default: state_d = OCC_EMPTY;
      endcase
      if (flush) begin
         state_d = OCC_EMPTY;
      end
   end

   // State, output and skid registers; reset clears all immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= OCC_EMPTY;
         out_imm_q  <= '0;
         out_tgt_q  <= '0;
         out_err_q  <= 1'b0;
         skid_imm_q <= '0;
         skid_tgt_q <= '0;
         skid_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         out_imm_q  <= out_imm_d;
         out_tgt_q  <= out_tgt_d;
         out_err_q  <= out_err_d;
         skid_imm_q <= skid_imm_d;
         skid_tgt_q <= skid_tgt_d;
         skid_err_q <= skid_err_d;
      end
   end

endmodule
